// File: rtl/uart_pkg.sv
// Shared UART definitions used by the transmitter and the on-chip receiver.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } uart_state_e;

  localparam int UART_DEFAULT_CLKS_PER_BIT = 10417;
  localparam int UART_DATA_BITS            = 8;

endpackage

// File: rtl/uart_baud_tick.sv
// Bit-period timer: down-counter emitting a one-cycle tick every CLKS_PER_BIT clocks.
// A synchronous clear restarts the period so the first tick lands CLKS_PER_BIT cycles later.
module uart_baud_tick #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clear_i,
  output logic tick_o
);

  localparam int CntW = $clog2(CLKS_PER_BIT);
  localparam logic [CntW-1:0] Reload = CntW'(CLKS_PER_BIT - 1);

  logic [CntW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q - CntW'(1);
    if (clear_i || (cnt_q == '0)) begin
      cnt_d = Reload;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tick_o = (cnt_q == '0);

endmodule

// File: rtl/uart_tx.sv
// UART transmitter, 8N1 LSB first with valid/ready byte input.
// Define UART_TX_PARITY_EN to insert an even-parity bit (8E1).
module uart_tx #(
  parameter int CLKS_PER_BIT = uart_pkg::UART_DEFAULT_CLKS_PER_BIT
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic [7:0] byte_i,
  input  logic       valid_i,
  output logic       ready_o,
  output logic       uart_rxd_o,
  output logic       busy_o
);
  import uart_pkg::*;

  localparam logic [2:0] LastBit = 3'(UART_DATA_BITS - 1);

  uart_state_e state_q;
  logic [7:0]  shift_q;
  logic [2:0]  bit_idx_q;
  logic        line_q;
  logic        tick;
  logic        accept;
`ifdef UART_TX_PARITY_EN
  logic        parity_q;
`endif

  assign accept = (state_q == IDLE) && valid_i;

  // Cleared on accept so the start bit is phase-aligned to the accept edge.
  uart_baud_tick #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud_tick (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .clear_i(accept),
    .tick_o (tick)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= IDLE;
      shift_q   <= '0;
      bit_idx_q <= '0;
      line_q    <= 1'b1;
`ifdef UART_TX_PARITY_EN
      parity_q  <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          line_q <= 1'b1;
          if (valid_i) begin
            shift_q   <= byte_i;
            bit_idx_q <= '0;
            line_q    <= 1'b0;
            state_q   <= START;
`ifdef UART_TX_PARITY_EN
            parity_q  <= ^byte_i;
`endif
          end
        end
        START: begin
          if (tick) begin
            line_q  <= shift_q[0];
            state_q <= DATA;
          end
        end
        DATA: begin
          if (tick) begin
            shift_q <= {1'b0, shift_q[7:1]};
            if (bit_idx_q == LastBit) begin
              bit_idx_q <= '0;
`ifdef UART_TX_PARITY_EN
              line_q    <= parity_q;
              state_q   <= PARITY;
`else
              line_q    <= 1'b1;
              state_q   <= STOP;
`endif
            end else begin
              bit_idx_q <= bit_idx_q + 3'd1;
              line_q    <= shift_q[1];
            end
          end
        end
`ifdef UART_TX_PARITY_EN
        PARITY: begin
          if (tick) begin
            line_q  <= 1'b1;
            state_q <= STOP;
          end
        end
`endif
        STOP: begin
          if (tick) begin
            line_q  <= 1'b1;
            state_q <= IDLE;
          end
        end
        default: begin
          line_q  <= 1'b1;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign ready_o    = (state_q == IDLE);
  assign busy_o     = !ready_o;
  assign uart_rxd_o = line_q;

endmodule

// File: tb/tb_uart_tx.sv
// Directed self-checking bench for uart_tx at CLKS_PER_BIT = 16.
// Define UART_TX_PARITY_EN for both bench and RTL to exercise the 8E1 frame.
module tb_uart_tx;

  localparam int C = 16;
`ifdef UART_TX_PARITY_EN
  localparam int F = 11;
`else
  localparam int F = 10;
`endif

  logic       clk;
  logic       rst_n;
  logic [7:0] byteIn;
  logic       validIn;
  logic       readyOut;
  logic       lineOut;
  logic       busyOut;

  int total = 0;
  int bad   = 0;

  uart_tx #(
    .CLKS_PER_BIT(C)
  ) dut (
    .clk_i     (clk),
    .rst_ni    (rst_n),
    .byte_i    (byteIn),
    .valid_i   (validIn),
    .ready_o   (readyOut),
    .uart_rxd_o(lineOut),
    .busy_o    (busyOut)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference line level for frame bit slot idx (0 = start, 1..8 = data, then parity/stop).
  function automatic logic expBit(input logic [7:0] b, input int idx);
    if (idx == 0) return 1'b0;
    if (idx <= 8) return b[idx-1];
    if (F == 11 && idx == 9) return ^b;
    return 1'b1;
  endfunction

  task automatic test_reset();
    rst_n   = 1'b0;
    validIn = 1'b0;
    byteIn  = 8'h00;
    repeat (5) @(negedge clk);
    total++;
    if (lineOut !== 1'b1 || readyOut !== 1'b1 || busyOut !== 1'b0) begin
      bad++;
      $display("[TB] FAIL reset_hold line/ready/busy got %b%b%b want 110", lineOut, readyOut, busyOut);
    end
    rst_n = 1'b1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      total++;
      if (lineOut !== 1'b1 || readyOut !== 1'b1 || busyOut !== 1'b0) begin
        bad++;
        $display("[TB] FAIL reset_idle cyc %0d line/ready/busy got %b%b%b want 110", i, lineOut, readyOut, busyOut);
      end
    end
  endtask

  task automatic test_single_byte(input logic [7:0] b, input string name);
    byteIn  = b;
    validIn = 1'b1;
    @(posedge clk);
    @(negedge clk);
    validIn = 1'b0;
    byteIn  = 8'hxx;
    for (int i = 0; i < F*C; i++) begin
      total++;
      if (lineOut !== expBit(b, i / C) || readyOut !== 1'b0 || busyOut !== 1'b1) begin
        bad++;
        $display("[TB] FAIL %s off %0d line/ready/busy got %b%b%b want %b01", name, i, lineOut, readyOut, busyOut, expBit(b, i / C));
      end
      @(negedge clk);
    end
    total++;
    if (readyOut !== 1'b1 || busyOut !== 1'b0 || lineOut !== 1'b1) begin
      bad++;
      $display("[TB] FAIL %s ready_rise line/ready/busy got %b%b%b want 110", name, lineOut, readyOut, busyOut);
    end
  endtask

  task automatic test_back_to_back();
    byteIn  = 8'h00;
    validIn = 1'b1;
    @(posedge clk);
    @(negedge clk);
    byteIn = 8'hFF;
    for (int i = 0; i < F*C; i++) begin
      total++;
      if (lineOut !== expBit(8'h00, i / C) || readyOut !== 1'b0) begin
        bad++;
        $display("[TB] FAIL b2b_first off %0d line/ready got %b%b want %b0", i, lineOut, readyOut, expBit(8'h00, i / C));
      end
      @(negedge clk);
    end
    total++;
    if (lineOut !== 1'b1 || readyOut !== 1'b1) begin
      bad++;
      $display("[TB] FAIL b2b_gap line/ready got %b%b want 11", lineOut, readyOut);
    end
    @(negedge clk);
    validIn = 1'b0;
    for (int i = 0; i < F*C; i++) begin
      total++;
      if (lineOut !== expBit(8'hFF, i / C) || readyOut !== 1'b0) begin
        bad++;
        $display("[TB] FAIL b2b_second off %0d line/ready got %b%b want %b0", i, lineOut, readyOut, expBit(8'hFF, i / C));
      end
      @(negedge clk);
    end
    total++;
    if (readyOut !== 1'b1 || lineOut !== 1'b1) begin
      bad++;
      $display("[TB] FAIL b2b_end line/ready got %b%b want 11", lineOut, readyOut);
    end
  endtask

  task automatic test_valid_ignored();
    byteIn  = 8'h81;
    validIn = 1'b1;
    @(posedge clk);
    @(negedge clk);
    validIn = 1'b0;
    for (int i = 0; i < F*C; i++) begin
      if (i == 50) begin
        byteIn  = 8'h3C;
        validIn = 1'b1;
      end
      if (i == 53) validIn = 1'b0;
      total++;
      if (lineOut !== expBit(8'h81, i / C) || readyOut !== 1'b0) begin
        bad++;
        $display("[TB] FAIL ignore off %0d line/ready got %b%b want %b0", i, lineOut, readyOut, expBit(8'h81, i / C));
      end
      @(negedge clk);
    end
    for (int i = 0; i < 20; i++) begin
      total++;
      if (lineOut !== 1'b1 || readyOut !== 1'b1) begin
        bad++;
        $display("[TB] FAIL ignore_after cyc %0d line/ready got %b%b want 11", i, lineOut, readyOut);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset_midframe();
    byteIn  = 8'h55;
    validIn = 1'b1;
    @(posedge clk);
    @(negedge clk);
    validIn = 1'b0;
    repeat (70) @(negedge clk);
    total++;
    if (lineOut !== 1'b0) begin
      bad++;
      $display("[TB] FAIL midrst_bit3 line got %b want 0", lineOut);
    end
    rst_n = 1'b0;
    #1;
    total++;
    if (lineOut !== 1'b1 || readyOut !== 1'b1 || busyOut !== 1'b0) begin
      bad++;
      $display("[TB] FAIL midrst_async line/ready/busy got %b%b%b want 110", lineOut, readyOut, busyOut);
    end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (C + 3) begin
      @(negedge clk);
      total++;
      if (lineOut !== 1'b1 || readyOut !== 1'b1) begin
        bad++;
        $display("[TB] FAIL midrst_idle line/ready got %b%b want 11", lineOut, readyOut);
      end
    end
    test_single_byte(8'h12, "after_rst_12");
  endtask

  initial begin
    $display("[TB] uart_tx bench, CLKS_PER_BIT=%0d frame bits=%0d", C, F);
    test_reset();
    test_single_byte(8'hA5, "single_A5");
    test_back_to_back();
    test_valid_ignored();
    test_reset_midframe();
`ifdef UART_TX_PARITY_EN
    test_single_byte(8'h07, "parity_07");
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
